// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - Moore serial pattern transmitter, MSB first, optional repeats with idle gaps.
// Repeat/gap support is enabled by defining PATTERN_TX_REPEAT_EN; default build sends one pattern per start.
module pattern_tx #(
    parameter int W   = 4,
    parameter int GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] pat_in,
    input  logic [3:0]   reps,
    input  logic         stop,
    output logic         out,
    output logic         out_vld,
    output logic         busy,
    output logic         done
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;

`ifdef PATTERN_TX_REPEAT_EN
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    logic [3:0] rep_cnt_q, rep_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
`else
    localparam logic [3:0] GAP_CFG = 4'(GAP);

    logic unused_cfg;
    assign unused_cfg = ^{reps, GAP_CFG};
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef PATTERN_TX_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d   = pat_in;
                    bit_cnt_d = LAST_BIT;
`ifdef PATTERN_TX_REPEAT_EN
                    rep_cnt_d = (reps == 4'd0) ? 4'd1 : reps;
`endif
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Rotation restores the captured pattern after W shifts, so repeats need no reload.
                shreg_d   = {shreg_q[W-2:0], shreg_q[W-1]};
                bit_cnt_d = bit_cnt_q - 1'b1;
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = LAST_BIT;
`ifdef PATTERN_TX_REPEAT_EN
                    rep_cnt_d = rep_cnt_q - 4'd1;
                    if (rep_cnt_q > 4'd1) begin
                        if (GAP > 0) begin
                            gap_cnt_d = GAP_LAST;
                            state_d   = S_GAP;
                        end else begin
                            state_d   = S_SHIFT;
                        end
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_GAP: begin
`ifdef PATTERN_TX_REPEAT_EN
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd0) begin
                    bit_cnt_d = LAST_BIT;
                    state_d   = S_SHIFT;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort outranks every transition; it has no meaning while idle.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
`ifdef PATTERN_TX_REPEAT_EN
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef PATTERN_TX_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign out     = (state_q == S_SHIFT) & shreg_q[W-1];
    assign out_vld = (state_q == S_SHIFT);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - table-driven bench for pattern_tx; expectations follow PATTERN_TX_REPEAT_EN.
module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pat_in = 4'h0;
    logic [3:0] reps = 4'h0;
    logic       stop = 1'b0;
    logic       out, out_vld, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       start;
        logic [3:0] pat;
        logic [3:0] reps;
        logic       stop;
        logic       rst;
        logic       e_out;
        logic       e_vld;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    pattern_tx #(.W(4), .GAP(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pat_in  (pat_in),
        .reps    (reps),
        .stop    (stop),
        .out     (out),
        .out_vld (out_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic add(input logic s, input logic [3:0] p, input logic [3:0] r,
                       input logic sp, input logic rs,
                       input logic eo, input logic ev, input logic eb, input logic ed);
        vec_t v;
        v.start = s; v.pat = p; v.reps = r; v.stop = sp; v.rst = rs;
        v.e_out = eo; v.e_vld = ev; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    // Start row plus the remaining bits; pat_in/reps are scrambled mid-run to prove no re-sampling.
    task automatic tx(input logic [3:0] p, input logic [3:0] r);
        add(1'b1, p, r, 1'b0, 1'b0, p[3], 1'b1, 1'b1, 1'b0);
        for (int i = 2; i >= 0; i--)
            add(1'b0, ~p, 4'hF, 1'b0, 1'b0, p[i], 1'b1, 1'b1, 1'b0);
    endtask

    task automatic shift_rows(input logic [3:0] p);
        for (int i = 3; i >= 0; i--)
            add(1'b0, ~p, 4'hF, 1'b0, 1'b0, p[i], 1'b1, 1'b1, 1'b0);
    endtask

    task automatic gap_row();  add(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic done_row(); add(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); endtask
    task automatic idle_row(); add(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

    task automatic chk(input string name, input int row, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    initial begin
        // Reset, also asserted together with start/stop
        add(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 4'hF, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_row();
        // Stop while idle is ignored
        add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single 1010 run: bits in cycles 1-4, done in 5, idle in 6
        tx(4'b1010, 4'd1); done_row(); idle_row();

        // Start re-asserted with 1111 during cycle 2 is ignored
        add(1'b1, 4'b1010, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'b1111, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'b1111, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        done_row(); idle_row(); idle_row();

        // Stop during the second SHIFT cycle: idle next, no done
        add(1'b1, 4'b1010, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'b1010, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'b1010, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_row(); idle_row();

`ifdef PATTERN_TX_REPEAT_EN
        // reps=3, GAP=1: 1010 gap 1010 gap 1010 done
        tx(4'b1010, 4'd3); gap_row(); shift_rows(4'b1010); gap_row(); shift_rows(4'b1010);
        done_row(); idle_row();

        // Reset during GAP, start/stop held alongside, then a fresh 0110 run
        tx(4'b1010, 4'd3); gap_row();
        add(1'b1, 4'hF, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tx(4'b0110, 4'd1); done_row(); idle_row();

        // Stop during GAP of a reps=2 run
        tx(4'b1001, 4'd2); gap_row();
        add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_row();
`else
        // reps ignored: a single pattern regardless of reps=5
        tx(4'b1010, 4'd5); done_row(); idle_row(); idle_row();

        // Reset mid-SHIFT, then a fresh 0110 run
        add(1'b1, 4'b1010, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'b1010, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tx(4'b0110, 4'd1); done_row(); idle_row();
`endif

        // reps=0 behaves as one pattern
        tx(4'b1100, 4'd0); done_row(); idle_row(); idle_row();

        // Stop during DONE: still idle afterwards, done does not repeat
        tx(4'b0011, 4'd1);
        add(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_row();

        foreach (vecs[i]) begin
            @(negedge clk);
            start  = vecs[i].start;
            pat_in = vecs[i].pat;
            reps   = vecs[i].reps;
            stop   = vecs[i].stop;
            rst    = vecs[i].rst;
            @(posedge clk);
            #1;
            chk("out",     i, out,     vecs[i].e_out);
            chk("out_vld", i, out_vld, vecs[i].e_vld);
            chk("busy",    i, busy,    vecs[i].e_busy);
            chk("done",    i, done,    vecs[i].e_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning pattern width in bits (2..16).
REQ-002 The block SHALL have parameter GAP, default 1, meaning idle cycles inserted between repeated patterns (0..15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning the synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning the request to begin transmission, sampled in IDLE only.
REQ-006 The block SHALL have port pat_in, input, W, meaning the pattern to transmit, captured on an accepted start.
REQ-007 The block SHALL have port reps, input, 4, meaning the number of pattern repetitions, captured on an accepted start.
REQ-008 The block SHALL have port stop, input, 1, meaning abort the current transmission.
REQ-009 The block SHALL have port out, output, 1, meaning the serial data bit.
REQ-010 The block SHALL have port out_vld, output, 1, meaning that out carries a pattern bit this cycle.
REQ-011 The block SHALL have port busy, output, 1, meaning the block is not in IDLE.
REQ-012 The block SHALL have port done, output, 1, meaning a one-cycle pulse at normal completion.

Function
REQ-013 The block SHALL be a Moore FSM: all outputs decode from registered state and datapath only, with no combinational path from any input to any output.
REQ-014 The FSM SHALL have states IDLE, SHIFT, GAP and DONE.
REQ-015 In IDLE: out=0, out_vld=0, busy=0, done=0; start=1 captures pat_in into the shift register, loads bit_cnt=W-1 and rep_cnt=max(reps,1), and moves to SHIFT.
REQ-016 In SHIFT: out=shreg[W-1] (MSB first), out_vld=1, busy=1; each cycle shreg rotates left by one and bit_cnt decrements.
REQ-017 On the SHIFT exit cycle (bit_cnt=0): rep_cnt decrements; rep_cnt>1 goes to GAP if GAP>0, otherwise back to SHIFT with bit_cnt=W-1; rep_cnt=1 goes to DONE.
REQ-018 Because shreg rotates, every repetition SHALL transmit the identical captured pattern, with no re-sampling of pat_in.
REQ-019 In GAP: out=0, out_vld=0, busy=1 for exactly GAP cycles, then SHIFT with bit_cnt=W-1.
REQ-020 In DONE: done=1, busy=1, out_vld=0 for one cycle, then IDLE.
REQ-021 Latency: with start accepted at edge k, the first bit SHALL be valid in the cycle after k; a run SHALL total W*N + GAP*(N-1) + 1 busy cycles.
REQ-022 start outside IDLE SHALL be ignored, and pat_in/reps changes outside IDLE SHALL have no effect.
REQ-023 stop=1 in SHIFT, GAP or DONE SHALL force IDLE at the next edge with no done pulse; stop in IDLE SHALL be ignored.
REQ-024 stop SHALL take priority over start and all state transitions.
REQ-025 reps=0 SHALL be treated as 1.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE and clear shreg, bit_cnt and rep_cnt, with out, out_vld, busy and done all 0 the following cycle.
REQ-027 rst SHALL override stop, start and any mid-transmission state.
REQ-028 rst SHALL not produce a done pulse.

Configuration
REQ-029 With macro PATTERN_TX_REPEAT_EN defined, reps SHALL be honoured as in REQ-015 to REQ-025.
REQ-030 Without PATTERN_TX_REPEAT_EN, reps SHALL be ignored and rep_cnt logic omitted, giving exactly one pattern per start and never entering GAP; the port list SHALL be unchanged.

Verification
REQ-031 The bench SHALL cover: W=4, pat_in=4'b1010, reps=1, start for 1 cycle -> out=1,0,1,0 with out_vld=1 in cycles 1-4, done=1 in cycle 5, busy=1 in cycles 1-5, IDLE in cycle 6.
REQ-032 The bench SHALL cover: pat_in=4'b1010, reps=3, GAP=1 (macro on) -> 1010, gap (out_vld=0), 1010, gap, 1010 over cycles 1-14, done in cycle 15.
REQ-033 The bench SHALL cover: start re-asserted with pat_in=4'b1111 during cycle 2 of a 1010 run -> the run is unchanged and no second run starts.
REQ-034 The bench SHALL cover: stop=1 during the second SHIFT cycle of a 1010 run -> IDLE next cycle, out_vld=0, done never asserted.
REQ-035 The bench SHALL cover: rst=1 during GAP of a reps=3 run -> all outputs 0 next cycle, then a fresh start with pat_in=4'b0110 transmits 0,1,1,0 correctly.
REQ-036 The bench SHALL cover: macro off, reps=5, pat_in=4'b1010 -> a single 1010 and done in cycle 5; reps=0 with macro on -> one pattern.
